// File: rtl/hazard_unit.sv
// Load-use stall and registered EX/MEM forwarding selects from a shadow pipeline.
// Define HAZARD_STATS_EN to add the saturating stall_count output.
module hazard_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [1:0]  id_read_rs,
   input  logic [1:0]  id_read_rt,
   input  logic        id_wr_en,
   input  logic [4:0]  id_wr_reg,
   input  logic        id_is_load,
   input  logic        flush,
   input  logic        hold,
   output logic        stall,
   output logic [1:0]  ex_fwd_rs,
   output logic [1:0]  ex_fwd_rt,
   output logic        mem_fwd_rt
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0] stall_count
`endif
);

   logic       exValid;
   logic [4:0] exReg;
   logic       exLoad;
   logic       exMemFwd;
   logic       memValid;
   logic [4:0] memReg;

   logic       exHitRs;
   logic       exHitRt;
   logic       memHitRs;
   logic       memHitRt;
   logic       bubble;
   logic [1:0] nxtRs;
   logic [1:0] nxtRt;
   logic       nxtMemFwd;

   // WB producers reach ID through the write-through register file,
   // so nothing past MEM needs to be tracked for matching.
   assign exHitRs  = exValid  && exReg  == id_rs && id_read_rs != 2'b00;
   assign exHitRt  = exValid  && exReg  == id_rt && id_read_rt != 2'b00;
   assign memHitRs = memValid && memReg == id_rs && id_read_rs != 2'b00;
   assign memHitRt = memValid && memReg == id_rt && id_read_rt != 2'b00;

   assign stall = id_valid && !flush && exLoad &&
                  ((exHitRs && id_read_rs == 2'b01) ||
                   (exHitRt && id_read_rt == 2'b01));

   assign bubble = stall || flush || !id_valid;

   always_comb begin
      nxtRs     = 2'b00;
      nxtRt     = 2'b00;
      nxtMemFwd = 1'b0;
      if (id_read_rs == 2'b01) begin
         if (exHitRs && !exLoad)
            nxtRs = 2'b01;
         else if (memHitRs)
            nxtRs = 2'b10;
      end
      case (id_read_rt)
         2'b01: begin
            if (exHitRt && !exLoad)
               nxtRt = 2'b01;
            else if (memHitRt)
               nxtRt = 2'b10;
         end
         // store data is consumed in MEM: an EX producer is caught from WB
         2'b10: begin
            if (exHitRt)
               nxtMemFwd = 1'b1;
            else if (memHitRt)
               nxtRt = 2'b10;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exValid    <= 1'b0;
         exReg      <= 5'd0;
         exLoad     <= 1'b0;
         exMemFwd   <= 1'b0;
         memValid   <= 1'b0;
         memReg     <= 5'd0;
         ex_fwd_rs  <= 2'b00;
         ex_fwd_rt  <= 2'b00;
         mem_fwd_rt <= 1'b0;
      end else if (!hold) begin
         memValid   <= exValid;
         memReg     <= exReg;
         mem_fwd_rt <= exMemFwd;
         if (bubble) begin
            exValid   <= 1'b0;
            exReg     <= 5'd0;
            exLoad    <= 1'b0;
            exMemFwd  <= 1'b0;
            ex_fwd_rs <= 2'b00;
            ex_fwd_rt <= 2'b00;
         end else begin
            exValid   <= id_wr_en && id_wr_reg != 5'd0;
            exReg     <= id_wr_reg;
            exLoad    <= id_is_load && id_wr_en && id_wr_reg != 5'd0;
            exMemFwd  <= nxtMemFwd;
            ex_fwd_rs <= nxtRs;
            ex_fwd_rt <= nxtRt;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_count <= 16'd0;
      else if (stall && !hold && stall_count != 16'hFFFF)
         stall_count <= stall_count + 16'd1;
   end
`endif

endmodule
